// File: rtl/rx_sample_decimator.sv
// Multi-channel I/Q decimator with pick and boxcar-average modes.
// Output uses a one-deep AXI-Stream holding register with drop accounting.
module rx_sample_decimator #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 2,
    parameter int RATIO_W  = 4,
    parameter int ACC_W    = WIDTH + RATIO_W
) (
    input  logic                      clk_32M768,
    input  logic                      rst_n_32M768,
    input  logic [RATIO_W-1:0]        cfg_ratio,
    input  logic                      cfg_mode,
    input  logic [RATIO_W-1:0]        cfg_shift,
    input  logic                      s_tvalid,
    input  logic [CHANNELS*WIDTH-1:0] s_tdata,
    input  logic                      s_sync,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [CHANNELS*WIDTH-1:0] m_tdata,
    output logic                      m_tuser,
    output logic                      overflow,
    output logic [15:0]               drop_cnt,
    input  logic                      clr_stat
);

    typedef enum logic {
        MODE_PICK = 1'b0,
        MODE_AVG  = 1'b1
    } mode_e;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

    logic [RATIO_W-1:0]        r_ratio;
    logic [RATIO_W-1:0]        r_shift;
    mode_e                     r_mode;
    logic [RATIO_W-1:0]        r_phase;
    logic signed [ACC_W-1:0]   r_acc [CHANNELS];
    logic                      r_first;
    logic                      r_valid;
    logic                      r_user;
    logic [CHANNELS*WIDTH-1:0] r_data;
    logic                      r_ovf;
    logic [15:0]               r_drop;

    logic                      w_load_cfg;
    logic [RATIO_W-1:0]        w_ratio;
    logic [RATIO_W-1:0]        w_shift;
    mode_e                     w_mode;
    logic [RATIO_W-1:0]        w_phase;
    logic                      w_start;
    logic                      w_last;
    logic                      w_cand_v;
    logic                      w_first;
    logic                      w_load_out;
    logic                      w_drop;
    logic signed [ACC_W-1:0]   w_ext [CHANNELS];
    logic signed [ACC_W-1:0]   w_sum [CHANNELS];
    logic signed [ACC_W-1:0]   w_shr [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] w_cand;

    // The beat that opens a window already uses the configuration latched with it.
    always_comb begin
        w_load_cfg = s_sync | (s_tvalid & (r_phase == '0));
        w_ratio    = w_load_cfg ? cfg_ratio : r_ratio;
        w_shift    = w_load_cfg ? cfg_shift : r_shift;
        w_mode     = w_load_cfg ? mode_e'(cfg_mode) : r_mode;
        w_phase    = s_sync ? '0 : r_phase;
        w_start    = (w_phase == '0);
        w_last     = (w_phase == w_ratio);
        w_cand_v   = s_tvalid & ((w_mode == MODE_PICK) ? w_start : w_last);
        w_first    = r_first | s_sync;
        w_load_out = w_cand_v & (~r_valid | m_tready);
        w_drop     = w_cand_v & r_valid & ~m_tready;
        w_cand     = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_ext[k] = {{(ACC_W - WIDTH){s_tdata[k*WIDTH + WIDTH - 1]}}, s_tdata[k*WIDTH +: WIDTH]};
            w_sum[k] = w_start ? w_ext[k] : r_acc[k] + w_ext[k];
            w_shr[k] = w_sum[k] >>> w_shift;
            if (w_mode == MODE_PICK)
                w_cand[k*WIDTH +: WIDTH] = s_tdata[k*WIDTH +: WIDTH];
            else if (w_shr[k] > SAT_MAX)
                w_cand[k*WIDTH +: WIDTH] = SAT_MAX[WIDTH-1:0];
            else if (w_shr[k] < SAT_MIN)
                w_cand[k*WIDTH +: WIDTH] = SAT_MIN[WIDTH-1:0];
            else
                w_cand[k*WIDTH +: WIDTH] = w_shr[k][WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            r_ratio <= cfg_ratio;
            r_shift <= cfg_shift;
            r_mode  <= mode_e'(cfg_mode);
            r_phase <= '0;
            for (int unsigned k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
            r_first <= 1'b1;
            r_valid <= 1'b0;
            r_user  <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            if (w_load_cfg) begin
                r_ratio <= cfg_ratio;
                r_shift <= cfg_shift;
                r_mode  <= mode_e'(cfg_mode);
            end

            if (s_tvalid) begin
                r_phase <= w_last ? '0 : w_phase + 1'b1;
                for (int unsigned k = 0; k < CHANNELS; k++) r_acc[k] <= w_sum[k];
            end else if (s_sync) begin
                r_phase <= '0;
                for (int unsigned k = 0; k < CHANNELS; k++) r_acc[k] <= '0;
            end

            if (w_load_out) begin
                r_valid <= 1'b1;
                r_data  <= w_cand;
                r_user  <= w_first;
            end else if (m_tready) begin
                r_valid <= 1'b0;
            end

            if (w_load_out)
                r_first <= 1'b0;
            else if (s_sync)
                r_first <= 1'b1;

            if (clr_stat) begin
                r_ovf  <= 1'b0;
                r_drop <= '0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != '1) r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign m_tvalid = r_valid;
    assign m_tdata  = r_data;
    assign m_tuser  = r_user;
    assign overflow = r_ovf;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_rx_sample_decimator.sv
// Directed self-checking bench for rx_sample_decimator (WIDTH=12, CHANNELS=2).
module tb_rx_sample_decimator;

    logic        clk_32M768 = 1'b0;
    logic        rst_n_32M768;
    logic [3:0]  cfg_ratio;
    logic        cfg_mode;
    logic [3:0]  cfg_shift;
    logic        s_tvalid;
    logic [23:0] s_tdata;
    logic        s_sync;
    logic        m_tvalid;
    logic        m_tready;
    logic [23:0] m_tdata;
    logic        m_tuser;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_stat;

    int n_checks = 0;
    int n_fail   = 0;

    always #15 clk_32M768 = ~clk_32M768;

    rx_sample_decimator #(
        .WIDTH    (12),
        .CHANNELS (2),
        .RATIO_W  (4)
    ) dut (
        .clk_32M768   (clk_32M768),
        .rst_n_32M768 (rst_n_32M768),
        .cfg_ratio    (cfg_ratio),
        .cfg_mode     (cfg_mode),
        .cfg_shift    (cfg_shift),
        .s_tvalid     (s_tvalid),
        .s_tdata      (s_tdata),
        .s_sync       (s_sync),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tuser      (m_tuser),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_stat     (clr_stat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int ei, input int eq, input logic eu);
        logic [11:0] wi;
        logic [11:0] wq;
        wi = 12'(ei);
        wq = 12'(eq);
        check({tag, "_valid"}, 32'(m_tvalid), 32'(1));
        check({tag, "_i"}, 32'(m_tdata[11:0]), 32'(wi));
        check({tag, "_q"}, 32'(m_tdata[23:12]), 32'(wq));
        check({tag, "_user"}, 32'(m_tuser), 32'(eu));
    endtask

    // Drive one cycle at the falling edge, sample 1 ns after the rising edge.
    task automatic beat(input logic v, input int i, input int q, input logic sync, input logic clr);
        @(negedge clk_32M768);
        s_tvalid = v;
        s_tdata  = {12'(q), 12'(i)};
        s_sync   = sync;
        clr_stat = clr;
        @(posedge clk_32M768);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] ratio, input logic mode, input logic [3:0] shift);
        @(negedge clk_32M768);
        rst_n_32M768 = 1'b0;
        s_tvalid = 1'b0;
        s_sync = 1'b0;
        clr_stat = 1'b0;
        cfg_ratio = ratio;
        cfg_mode = mode;
        cfg_shift = shift;
        @(posedge clk_32M768);
        #1;
        check("rst_valid", 32'(m_tvalid), 32'(0));
        check("rst_data", 32'(m_tdata), 32'(0));
        check("rst_user", 32'(m_tuser), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_drop", 32'(drop_cnt), 32'(0));
        @(negedge clk_32M768);
        rst_n_32M768 = 1'b1;
        m_tready = 1'b1;
    endtask

    initial begin
        rst_n_32M768 = 1'b0;
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_sync = 1'b0;
        clr_stat = 1'b0;
        cfg_ratio = '0;
        cfg_mode = 1'b0;
        cfg_shift = '0;

        // Pick, N=12, ramp input
        do_reset(4'd11, 1'b0, 4'd0);
        for (int n = 0; n < 36; n++) begin
            beat(1'b1, n, -n, 1'b0, 1'b0);
            if (n % 12 == 0) check_out("pick", n, -n, n == 0);
            else check("pick_idle", 32'(m_tvalid), 32'(0));
        end

        // Average, N=4, shift 2, constant input
        do_reset(4'd3, 1'b1, 4'd2);
        for (int n = 0; n < 8; n++) begin
            beat(1'b1, 100, -100, 1'b0, 1'b0);
            if (n % 4 == 3) check_out("avg", 100, -100, n == 3);
            else check("avg_idle", 32'(m_tvalid), 32'(0));
        end

        // Average, N=4, shift 0: I saturates high, Q = -400 in range
        do_reset(4'd3, 1'b1, 4'd0);
        for (int n = 0; n < 4; n++) beat(1'b1, 2047, -100, 1'b0, 1'b0);
        check_out("avg_sat", 2047, -400, 1'b1);

        // Average, N=16, shift 0: extreme sums saturate both ways
        do_reset(4'd15, 1'b1, 4'd0);
        for (int n = 0; n < 16; n++) begin
            beat(1'b1, -2048, 2047, 1'b0, 1'b0);
            if (n == 14) check("avg16_idle", 32'(m_tvalid), 32'(0));
        end
        check_out("avg16", -2048, 2047, 1'b1);

        // N=1 average with shift 1: arithmetic shift truncates toward -inf
        do_reset(4'd0, 1'b1, 4'd1);
        beat(1'b1, 10, -7, 1'b0, 1'b0);
        check_out("n1_a", 5, -4, 1'b1);
        beat(1'b1, -7, 10, 1'b0, 1'b0);
        check_out("n1_b", -4, 5, 1'b0);

        // Backpressure across 3 windows at N=4
        do_reset(4'd3, 1'b1, 4'd2);
        m_tready = 1'b0;
        for (int w = 1; w <= 3; w++)
            for (int n = 0; n < 4; n++) beat(1'b1, 100 * w, 0, 1'b0, 1'b0);
        check_out("hold", 100, 0, 1'b1);
        check("hold_ovf", 32'(overflow), 32'(1));
        check("hold_drop", 32'(drop_cnt), 32'(2));
        beat(1'b0, 0, 0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 32'(0));
        check("clr_drop", 32'(drop_cnt), 32'(0));
        check("clr_hold", 32'(m_tvalid), 32'(1));
        // Reset taken while the beat is still held (do_reset checks m_tvalid=0)

        // s_sync at phase 2 restarts the window
        do_reset(4'd3, 1'b1, 4'd0);
        for (int n = 1; n <= 4; n++) beat(1'b1, n, -n, 1'b0, 1'b0);
        check_out("sync_w1", 10, -10, 1'b1);
        beat(1'b1, 5, -5, 1'b0, 1'b0);
        beat(1'b1, 6, -6, 1'b0, 1'b0);
        beat(1'b1, 10, -10, 1'b1, 1'b0);
        beat(1'b1, 20, -20, 1'b0, 1'b0);
        check("sync_idle", 32'(m_tvalid), 32'(0));
        beat(1'b1, 30, -30, 1'b0, 1'b0);
        beat(1'b1, 40, -40, 1'b0, 1'b0);
        check_out("sync_w2", 100, -100, 1'b1);

        // Ratio change mid-window applies from the next window
        do_reset(4'd3, 1'b1, 4'd0);
        beat(1'b1, 1, 0, 1'b0, 1'b0);
        beat(1'b1, 2, 0, 1'b0, 1'b0);
        cfg_ratio = 4'd1;
        beat(1'b1, 3, 0, 1'b0, 1'b0);
        check("ratio_idle3", 32'(m_tvalid), 32'(0));
        beat(1'b1, 4, 0, 1'b0, 1'b0);
        check_out("ratio_w4", 10, 0, 1'b1);
        beat(1'b1, 5, 0, 1'b0, 1'b0);
        check("ratio_idle5", 32'(m_tvalid), 32'(0));
        beat(1'b1, 6, 0, 1'b0, 1'b0);
        check_out("ratio_w2a", 11, 0, 1'b0);
        beat(1'b1, 7, 0, 1'b0, 1'b0);
        beat(1'b1, 8, 0, 1'b0, 1'b0);
        check_out("ratio_w2b", 15, 0, 1'b0);

        beat(1'b0, 0, 0, 1'b0, 1'b0);
        check("final_idle", 32'(m_tvalid), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_sample_decimator.md
Name: rx_sample_decimator

Overview:
Parametrised successor to the fixed divide-by-12 Rx write-enable gating. Decimates a multi-channel signed I/Q sample stream by a runtime ratio of 1..2^RATIO_W, in one of two modes: pick (keep phase-0 sample) or boxcar average (accumulate-and-dump, shift, saturate). Sits between the ADC async FIFO output and the Rx chain in the 32.768 MHz domain. Drives an AXI-Stream-style output with a one-deep holding register, a drop counter and a sticky overflow flag.

Parameters:
WIDTH, 12, bits per channel sample (signed two's complement)
CHANNELS, 2, number of packed channels (e.g. I and Q)
RATIO_W, 4, width of cfg_ratio; decimation N = cfg_ratio+1, range 1..2^RATIO_W
ACC_W, WIDTH+RATIO_W, accumulator width per channel; never overflows

Ports:
clk_32M768  in  1  block clock
rst_n_32M768  in  1  synchronous active-low reset
cfg_ratio  in  RATIO_W  decimation ratio minus one
cfg_mode  in  1  0 = pick, 1 = boxcar average
cfg_shift  in  RATIO_W  arithmetic right shift applied to sum in average mode
s_tvalid  in  1  input beat valid; no backpressure, so every valid beat is consumed
s_tdata  in  CHANNELS*WIDTH  packed samples; channel k at [k*WIDTH +: WIDTH]
s_sync  in  1  window restart pulse, e.g. derived from RX_FRAME alignment
m_tvalid  out  1  output beat valid
m_tready  in  1  downstream ready
m_tdata  out  CHANNELS*WIDTH  decimated samples, same packing
m_tuser  out  1  high on first output beat after reset or s_sync
overflow  out  1  sticky: an output beat was dropped
drop_cnt  out  16  count of dropped beats, saturating at 0xFFFF
clr_stat  in  1  clears overflow and drop_cnt

Behaviour:
- Reset (rst_n_32M768 = 0 at clock edge): m_tvalid, m_tdata, m_tuser, overflow, drop_cnt, phase counter and accumulators all go to 0. A first-flag register is set to 1. The active configuration registers load cfg_ratio, cfg_mode and cfg_shift.
- Phase counter: advances only on s_tvalid, wraps from N-1 to 0. Non-valid cycles hold all state.
- Configuration latching: cfg_* is sampled into active registers only when a beat is accepted at phase 0, or on s_sync. Changes made mid-window take effect at the next window.
- Pick mode: the beat accepted at phase 0 becomes the output candidate. Its latency to m_tvalid is 1 clock. All other beats are discarded.
- Average mode:
  - Each channel is sign-extended to ACC_W.
  - The phase-0 beat loads the accumulator; later beats add to it.
  - On the beat at phase N-1, the output candidate is (acc + current sample) >>> cfg_shift, truncated rather than rounded, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1] per channel.
  - Latency from the last beat of the window to m_tvalid is 1 clock.
- N = 1: every valid beat produces an output, in both modes. Average mode then outputs sample >>> cfg_shift, saturated.
- Output handshake:
  - A transfer occurs when m_tvalid && m_tready.
  - When a candidate is produced and the holding register is empty, or is being transferred in the same cycle, the register loads: m_tvalid = 1, m_tuser = first flag, and the first flag clears.
  - When a candidate is produced while m_tvalid && !m_tready, the candidate is dropped. The held beat stays unchanged, overflow is set, and drop_cnt increments by 1, saturating.
  - m_tdata and m_tuser stay stable while m_tvalid && !m_tready.
- s_sync:
  - Forces phase to 0, discards any partial accumulation and sets the first flag. The holding register is untouched.
  - If s_sync and s_tvalid occur in the same cycle, that beat is treated as phase 0 of the new window, using freshly latched cfg.
- clr_stat occurring together with a drop: the clear wins, leaving overflow = 0 and drop_cnt = 0.
- Reset asserted mid-window or mid-handshake: everything returns to reset values and the held beat is lost.

Test Plan:
- Pick, cfg_ratio = 11, continuous s_tvalid, ramp input 0,1,2,…: outputs 0, 12, 24, … one clock after the corresponding beat; m_tuser = 1 only on the beat carrying 0.
- Average, cfg_ratio = 3, cfg_shift = 2, constant I = 100, Q = -100: every output beat is I = 100, Q = -100. Repeat with I = 2047 and cfg_shift = 0: output saturates to 2047.
- Average, cfg_ratio = 15, cfg_shift = 0, I = -2048 for all beats: sum = -32768 fits in ACC_W; output saturates to -2048.
- Hold m_tready = 0 across 3 windows at N = 4: the first beat is held unchanged, overflow = 1, drop_cnt = 2. Pulse clr_stat: overflow = 0, drop_cnt = 0.
- Assert s_sync at phase 2 of an N = 4 average window: the partial sum is discarded, the next output covers the 4 beats starting at the sync beat, and m_tuser = 1.
- Change cfg_ratio from 3 to 1 mid-window: the current window completes at N = 4, and subsequent windows use N = 2.
